// File: rtl/sync_filter_if.sv
// Pin-side bundle for sync_filter: raw asynchronous inputs in, and the
// filtered level with its edge pulses out.
interface sync_filter_if #(
    parameter int p_width = 4
);
    logic [p_width-1:0] d;
    logic [p_width-1:0] d_o;
    logic [p_width-1:0] d_o_pe;
    logic [p_width-1:0] d_o_ne;
    logic               d_o_chg;

    modport master (output d, input d_o, d_o_pe, d_o_ne, d_o_chg);
    modport slave  (input d, output d_o, d_o_pe, d_o_ne, d_o_chg);
endinterface

// File: rtl/sync_filter.sv
// Per-channel synchroniser followed by a stability (deglitch) filter, with
// registered rising/falling pulses aligned to the filtered level.
module sync_filter #(
    parameter int                 p_width       = 4,
    parameter int                 p_sync_stages = 2,
    parameter int                 p_filt_len    = 4,
    parameter logic [p_width-1:0] p_rst_val     = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    sync_filter_if.slave  bus
);
    localparam int               CNT_W   = (p_filt_len > 1) ? $clog2(p_filt_len) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(p_filt_len - 1);

    logic [p_sync_stages-1:0] sync_q [p_width];
    logic [p_sync_stages-1:0] sync_d [p_width];
    logic [CNT_W-1:0]         cnt_q  [p_width];
    logic [CNT_W-1:0]         cnt_d  [p_width];
    logic [p_width-1:0]       filt_q, filt_d;
    logic [p_width-1:0]       pe_q, pe_d;
    logic [p_width-1:0]       ne_q, ne_d;
    logic                     chg_q, chg_d;
    logic                     x;

    always_comb begin
        chg_d = 1'b0;
        x     = 1'b0;
        for (int i = 0; i < p_width; i++) begin
            sync_d[i] = {sync_q[i][p_sync_stages-2:0], bus.d[i]};
            filt_d[i] = filt_q[i];
            cnt_d[i]  = '0;
            pe_d[i]   = 1'b0;
            ne_d[i]   = 1'b0;
            x         = sync_q[i][p_sync_stages-1];
            // Any agreement between x and the level discards a partial count.
            if (x != filt_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    filt_d[i] = x;
                    pe_d[i]   = x;
                    ne_d[i]   = ~x;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        chg_d = |(pe_d | ne_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < p_width; i++) begin
                sync_q[i] <= {p_sync_stages{p_rst_val[i]}};
                cnt_q[i]  <= '0;
            end
            filt_q <= p_rst_val;
            pe_q   <= '0;
            ne_q   <= '0;
            chg_q  <= 1'b0;
        end else begin
            for (int i = 0; i < p_width; i++) begin
                sync_q[i] <= sync_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            filt_q <= filt_d;
            pe_q   <= pe_d;
            ne_q   <= ne_d;
            chg_q  <= chg_d;
        end
    end

    assign bus.d_o     = filt_q;
    assign bus.d_o_pe  = pe_q;
    assign bus.d_o_ne  = ne_q;
    assign bus.d_o_chg = chg_q;
endmodule

// File: tb/tb_sync_filter.sv
// Bench for sync_filter: default instance (2 sync, filter 4) and a
// pass-through instance (3 sync, filter 1), checked against a stability model.
module tb_sync_filter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   started = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    sync_filter_if #(.p_width(4)) bus_a ();
    sync_filter_if #(.p_width(4)) bus_b ();

    sync_filter #(.p_width(4), .p_sync_stages(2), .p_filt_len(4), .p_rst_val(4'h0))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    sync_filter #(.p_width(4), .p_sync_stages(3), .p_filt_len(1), .p_rst_val(4'h0))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    // Model: x is the input sample taken S edges earlier (reset level before
    // that); the level flips once the last L x values since reset all differ.
    int         s_len [2] = '{2, 3};
    int         l_len [2] = '{4, 1};
    logic [3:0] hist  [2][8];
    logic [3:0] xs    [2][8];
    int         xn    [2];
    logic [3:0] mf    [2];
    logic [3:0] mpe   [2];
    logic [3:0] mne   [2];
    logic       mchg  [2];

    task automatic model_step(input int k, input logic [3:0] din);
        logic [3:0] x, nf;
        bit         stable;
        if (!rst_n) begin
            for (int j = 0; j < 8; j++) hist[k][j] = 4'h0;
            xn[k] = 0;
            mf[k] = 4'h0; mpe[k] = 4'h0; mne[k] = 4'h0; mchg[k] = 1'b0;
        end else begin
            x = hist[k][s_len[k]-1];
            for (int j = 7; j > 0; j--) hist[k][j] = hist[k][j-1];
            hist[k][0] = din;
            for (int j = 7; j > 0; j--) xs[k][j] = xs[k][j-1];
            xs[k][0] = x;
            if (xn[k] < 8) xn[k]++;
            nf = mf[k];
            for (int b = 0; b < 4; b++) begin
                if (xn[k] >= l_len[k]) begin
                    stable = 1'b1;
                    for (int t = 0; t < l_len[k]; t++)
                        if (xs[k][t][b] == mf[k][b]) stable = 1'b0;
                    if (stable) nf[b] = ~mf[k][b];
                end
            end
            mpe[k]  = nf & ~mf[k];
            mne[k]  = ~nf & mf[k];
            mchg[k] = |(mpe[k] | mne[k]);
            mf[k]   = nf;
        end
    endtask

    always @(posedge clk) begin
        model_step(0, bus_a.d);
        model_step(1, bus_b.d);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("a_d_o",   32'(bus_a.d_o),     32'(mf[0]));
            chk("a_pe",    32'(bus_a.d_o_pe),  32'(mpe[0]));
            chk("a_ne",    32'(bus_a.d_o_ne),  32'(mne[0]));
            chk("a_chg",   32'(bus_a.d_o_chg), 32'(mchg[0]));
            chk("b_d_o",   32'(bus_b.d_o),     32'(mf[1]));
            chk("b_pe",    32'(bus_b.d_o_pe),  32'(mpe[1]));
            chk("b_ne",    32'(bus_b.d_o_ne),  32'(mne[1]));
            chk("b_chg",   32'(bus_b.d_o_chg), 32'(mchg[1]));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus_a.d = 4'hF;
        bus_b.d = 4'h0;
        // Reset with all inputs high
        step(1);
        started = 1'b1;
        step(2);
        chk("rst_d_o", 32'(bus_a.d_o), 32'h0);
        chk("rst_pe",  32'(bus_a.d_o_pe), 32'h0);
        chk("rst_chg", 32'(bus_a.d_o_chg), 32'h0);
        rst_n = 1'b1;
        step(5);
        chk("rel_e5_d_o", 32'(bus_a.d_o), 32'h0);
        step(1);
        chk("rel_e6_d_o", 32'(bus_a.d_o), 32'hF);
        chk("rel_e6_pe",  32'(bus_a.d_o_pe), 32'hF);
        chk("rel_e6_chg", 32'(bus_a.d_o_chg), 32'h1);
        step(1);
        chk("rel_e7_pe",  32'(bus_a.d_o_pe), 32'h0);
        chk("rel_e7_chg", 32'(bus_a.d_o_chg), 32'h0);
        bus_a.d = 4'h0;
        step(10);

        // Glitch of 3 clocks on channel 0
        bus_a.d = 4'h1;
        step(3);
        bus_a.d = 4'h0;
        step(10);
        chk("glitch_d_o", 32'(bus_a.d_o), 32'h0);

        // Exactly 4 clocks on channel 0
        bus_a.d = 4'h1;
        step(4);
        bus_a.d = 4'h0;
        step(1);
        chk("acc_e5_d_o", 32'(bus_a.d_o), 32'h0);
        step(1);
        chk("acc_e6_d_o", 32'(bus_a.d_o), 32'h1);
        chk("acc_e6_pe",  32'(bus_a.d_o_pe), 32'h1);
        step(4);
        chk("acc_e10_d_o", 32'(bus_a.d_o), 32'h0);
        chk("acc_e10_ne",  32'(bus_a.d_o_ne), 32'h1);
        step(6);

        // Simultaneous rise and fall on different channels
        bus_a.d = 4'b0100;
        step(10);
        bus_a.d = 4'b0010;
        step(6);
        chk("sim_pe",  32'(bus_a.d_o_pe), 32'b0010);
        chk("sim_ne",  32'(bus_a.d_o_ne), 32'b0100);
        chk("sim_chg", 32'(bus_a.d_o_chg), 32'h1);
        step(1);
        chk("sim_chg_off", 32'(bus_a.d_o_chg), 32'h0);
        step(4);

        // Chatter on channel 3
        for (int i = 0; i < 20; i++) begin
            bus_a.d[3] = ~bus_a.d[3];
            step(1);
        end
        bus_a.d[3] = 1'b0;
        step(10);
        chk("chat_d_o", 32'(bus_a.d_o), 32'b0010);
        bus_a.d = 4'h0;
        step(10);

        // Reset while channel 1 is mid-count
        bus_a.d = 4'b0010;
        step(4);
        rst_n = 1'b0;
        step(1);
        chk("mid_d_o", 32'(bus_a.d_o), 32'h0);
        chk("mid_pe",  32'(bus_a.d_o_pe), 32'h0);
        rst_n = 1'b1;
        step(5);
        chk("mid_e5_d_o", 32'(bus_a.d_o), 32'h0);
        step(1);
        chk("mid_e6_d_o", 32'(bus_a.d_o), 32'b0010);
        chk("mid_e6_pe",  32'(bus_a.d_o_pe), 32'b0010);
        step(3);

        // Pass-through instance: latency and 1-cycle pulses
        bus_b.d = 4'h1;
        step(3);
        chk("b_lat_e3_d_o", 32'(bus_b.d_o), 32'h0);
        step(1);
        chk("b_lat_e4_d_o", 32'(bus_b.d_o), 32'h1);
        chk("b_lat_e4_pe",  32'(bus_b.d_o_pe), 32'h1);
        bus_b.d = 4'h5;
        step(1);
        bus_b.d = 4'h1;
        step(2);
        chk("b_pul_e3_d_o", 32'(bus_b.d_o), 32'h1);
        step(1);
        chk("b_pul_e4_d_o", 32'(bus_b.d_o), 32'h5);
        chk("b_pul_e4_pe",  32'(bus_b.d_o_pe), 32'h4);
        step(1);
        chk("b_pul_e5_d_o", 32'(bus_b.d_o), 32'h1);
        chk("b_pul_e5_ne",  32'(bus_b.d_o_ne), 32'h4);
        step(5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/sync_filter.md
# sync_filter

Multi-channel input conditioner: each of `p_width` asynchronous inputs passes through a `p_sync_stages`-deep synchroniser, then a digital deglitch filter that accepts a new level only after it has been stable for `p_filt_len` consecutive clocks. Registered one-cycle rising- and falling-edge pulses are aligned with the filtered level, plus a combined change flag. It sits at the boundary between external pins (SPI chip-select, mode straps, buttons) and any logic in the `clk` domain that needs clean levels and edges.

## Interface

Parameters:
- `p_width`, 4, number of independent channels (≥1)
- `p_sync_stages`, 2, synchroniser depth per channel (≥2)
- `p_filt_len`, 4, required stable cycles before the filtered level changes (≥1); counter width is max(1, clog2(`p_filt_len`))
- `p_rst_val`, '0, `p_width`-bit reset level for the sync chain and filtered output

Ports:
- `clk`  input  1  single clock; all logic on posedge
- `rst_n`  input  1  reset, synchronous and active-low
- `d`  input  `p_width`  asynchronous raw inputs
- `d_o`  output  `p_width`  filtered synchronised level, registered
- `d_o_pe`  output  `p_width`  one-cycle pulse, filtered level went 0→1, registered
- `d_o_ne`  output  `p_width`  one-cycle pulse, filtered level went 1→0, registered
- `d_o_chg`  output  1  registered OR over all bits of `d_o_pe | d_o_ne`

## Operation

- Per channel i: shift chain `s[p_sync_stages-1:0]`, `s[0] <= d[i]`; synchronised sample `x = s[p_sync_stages-1]`.
- Filter state per channel: level `f` (drives `d_o[i]`) and counter `cnt`.
- Each edge, per channel:
  - `x == f`: `cnt <= 0`; no pulse.
  - `x != f` and `cnt == p_filt_len-1`: `f <= x`, `cnt <= 0`, assert `d_o_pe[i]` if `x` = 1, else `d_o_ne[i]`, for exactly one cycle.
  - `x != f` otherwise: `cnt <= cnt + 1`.
- Any return of `x` to `f` before the count completes clears `cnt`; the partial count is discarded (glitch rejected).
- `cnt` never exceeds `p_filt_len-1`; no wrap-around.
- Channels are fully independent; simultaneous transitions on several channels produce simultaneous pulses; `d_o_chg` is a single cycle high in that case.
- `p_filt_len` = 1: filter is a pass-through register; `f` follows `x` with one cycle delay.
- Reset (`rst_n` low at posedge): every `s` stage and `f` take `p_rst_val[i]`, `cnt` = 0, `d_o_pe` = `d_o_ne` = 0, `d_o_chg` = 0. Reset mid-count abandons the count. Reset release itself never produces a pulse. If `d` differs from `p_rst_val` after release, a normal filtered transition with its pulse follows.

## Timing

- Reset values: `d_o` = `p_rst_val`, `d_o_pe` = `d_o_ne` = 0, `d_o_chg` = 0.
- Latency: a level on `d[i]` stable from posedge E1, where E1 is the first edge that samples it, appears on `d_o[i]` after edge E1 + `p_sync_stages` + `p_filt_len` − 1. Defaults: the 6th edge counting E1 as the 1st.
- `d_o_pe`/`d_o_ne` are high in exactly the cycle in which `d_o` first shows the new level.
- `d_o_chg` is aligned with the pulses.
- Minimum accepted pulse width: `p_filt_len` cycles as seen at `x`. Shorter pulses never reach `d_o`.
- Two opposite pulses on the same channel are separated by at least `p_filt_len` cycles.

## Test plan

- Reset: defaults, `d` = 4'hF, `rst_n` low 3 edges → all outputs 0. After release, `d_o` = 4'hF at the 6th edge, `d_o_pe` = 4'hF for 1 cycle, `d_o_chg` = 1 for 1 cycle.
- Glitch reject: `d[0]` high for 3 clocks, then low → `d_o[0]` stays 0; no `d_o_pe`/`d_o_ne`/`d_o_chg` ever asserted.
- Accept threshold: `d[0]` high for exactly 4 clocks, then low → `d_o[0]` 0→1 at edge 6 with `d_o_pe[0]` pulse. It returns to 0 four cycles later with a `d_o_ne[0]` pulse.
- Simultaneous: from `d` = 4'b0100 settled, drive 4'b0010 in one cycle → `d_o_pe` = 4'b0010 and `d_o_ne` = 4'b0100 in the same single cycle; `d_o_chg` high once.
- Chatter: `d[3]` toggled every clock for 20 clocks, then held 0 → `d_o[3]` never changes; no pulses.
- Reset mid-count: `d[1]` high long enough that `cnt` = 2, then `rst_n` low 1 edge with `d[1]` still high → `d_o[1]` = 0, no pulse. After release, `d_o[1]` rises 6 edges later with exactly one `d_o_pe[1]` pulse.
- Parameter sweep: `p_filt_len` = 1, `p_sync_stages` = 3 → latency 3 edges; 1-cycle input pulses are passed through.
